// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver for the mod60 counter.
// Frame-aligned shadow latch, lead-zero blanking and a dp heartbeat.
module seg7_scan_driver #(
  parameter int SCAN_DIV        = 50000,
  parameter int BLINK_FRAMES    = 100,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter bit BLANK_LEAD_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [3:0] led1,
  input  logic [3:0] led2,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_UNITS = 2'd1;
  localparam logic [1:0] S_TENS  = 2'd2;

  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [1:0] AN_OFF  = {2{ACTIVE_LOW}};

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic       tick;
  logic       latch;
  logic [6:0] seg_raw;
  logic [1:0] an_raw;
  logic       dp_raw;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (presc_q == PRE_MAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    state_d  = state_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    latch    = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_UNITS;
          latch   = 1'b1;
        end
        S_UNITS: state_d = S_TENS;
        S_TENS: begin
          state_d = S_UNITS;
          latch   = 1'b1;
          if (frame_q == FRM_MAX) begin
            frame_d = '0;
            blink_d = ~blink_q;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (latch) shadow_d = {led2, led1};
  end

  // Outputs are derived from the next state so they change with it.
  always_comb begin
    seg_raw = 7'h00;
    an_raw  = 2'b00;
    dp_raw  = 1'b0;
    case (state_d)
      S_UNITS: begin
        an_raw  = 2'b01;
        seg_raw = decode(shadow_d[3:0]);
        dp_raw  = blink_d;
      end
      S_TENS: begin
        an_raw = 2'b10;
        if (BLANK_LEAD_ZERO && shadow_d[7:4] == 4'd0)
          seg_raw = 7'h00;
        else
          seg_raw = decode(shadow_d[7:4]);
      end
      default: ;
    endcase

    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (tick) begin
      seg_d = seg_raw ^ SEG_OFF;
      an_d  = an_raw ^ AN_OFF;
      dp_d  = dp_raw ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      presc_q  <= '0;
      state_q  <= S_IDLE;
      shadow_q <= '0;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      dp_q     <= ACTIVE_LOW;
    end else begin
      presc_q  <= presc_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
